noc_input_route_ctrl: RTL and testbench

//  Clocked input-port controller for a binary-tree NoC router. Accepts one

---
 rtl/noc_input_route_ctrl.sv | 88 ++++++++
 tb/tb_noc_input_route_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_route_ctrl.sv
// noc_input_route_ctrl
// Input-port controller for a binary-tree NoC router. Each packet arriving on
// the valid/ready input is steered to one of two single-entry output slots,
// chosen by the destination field ANDed with MASK. A slot can accept a new
// packet in the same cycle it drains, which sustains one packet per cycle.
// A stalled slot blocks the input only while the head packet targets it.

module noc_input_route_ctrl #(
    parameter int unsigned             WIDTH_packet = 14,
    parameter int unsigned             ADDR_W       = 3,
    parameter logic [ADDR_W-1:0]       MASK         = 3'b001
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_packet-1:0] in_data,

    output logic                    out1_valid,
    input  logic                    out1_ready,
    output logic [WIDTH_packet-1:0] out1_data,

    output logic                    out2_valid,
    input  logic                    out2_ready,
    output logic [WIDTH_packet-1:0] out2_data
);

    // Destination field sits in the top ADDR_W bits of the packet.
    logic [ADDR_W-1:0]       w_dest;
    logic                    w_to_out2;
    logic                    w_slot1_free;
    logic                    w_slot2_free;
    logic                    w_accept;
    logic                    w_load1;
    logic                    w_load2;

    logic                    r_out1_valid;
    logic [WIDTH_packet-1:0] r_out1_data;
    logic                    r_out2_valid;
    logic [WIDTH_packet-1:0] r_out2_data;

    // Route decode, acceptance and per-slot load strobes.
    always_comb begin
        w_dest       = in_data[WIDTH_packet-1 -: ADDR_W];
        w_to_out2    = |(w_dest & MASK);
        // A slot can take a packet when empty or when it is draining this edge.
        w_slot1_free = !r_out1_valid || out1_ready;
        w_slot2_free = !r_out2_valid || out2_ready;
        // Ready follows the head packet's target only; held low during reset.
        in_ready     = rst_n && (w_to_out2 ? w_slot2_free : w_slot1_free);
        w_accept     = in_valid && in_ready;
        w_load1      = w_accept && !w_to_out2;
        w_load2      = w_accept &&  w_to_out2;
    end

    // Port-1 slot: load wins over drain so a same-edge reload keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out1_valid <= 1'b0;
            r_out1_data  <= '0;
        end else if (w_load1) begin
            r_out1_valid <= 1'b1;
            r_out1_data  <= in_data;
        end else if (out1_ready) begin
            r_out1_valid <= 1'b0;
        end
    end

    // Port-2 slot: same behaviour as port 1, drained independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out2_valid <= 1'b0;
            r_out2_data  <= '0;
        end else if (w_load2) begin
            r_out2_valid <= 1'b1;
            r_out2_data  <= in_data;
        end else if (out2_ready) begin
            r_out2_valid <= 1'b0;
        end
    end

    assign out1_valid = r_out1_valid;
    assign out1_data  = r_out1_data;
    assign out2_valid = r_out2_valid;
    assign out2_data  = r_out2_data;

endmodule

// File: tb/tb_noc_input_route_ctrl.sv
// tb_noc_input_route_ctrl
// Table-driven routing vectors plus hand-written multi-cycle sequences, with a
// per-port scoreboard that queues accepted packets and matches every output
// transfer against them in order.

module tb_noc_input_route_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [13:0] out1_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [13:0] out2_data;

    int n_tests;
    int n_fail;

    logic [13:0] q1[$];
    logic [13:0] q2[$];

    typedef struct packed {
        logic [13:0] data;
        logic        to_out2;
    } vec_t;

    vec_t        vecs[6];
    logic [13:0] tp[4];

    noc_input_route_ctrl #(
        .WIDTH_packet(14),
        .ADDR_W      (3),
        .MASK        (3'b001)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data),
        .out2_valid(out2_valid),
        .out2_ready(out2_ready),
        .out2_data (out2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs are stable at the falling edge, so transfers
    // seen here are the ones that happen on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out1 unexpected packet: got %h expected none", out1_data);
                end else begin
                    check("out1 order", 16'(out1_data), 16'(q1.pop_front()));
                end
            end
            if (out2_valid && out2_ready) begin
                if (q2.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out2 unexpected packet: got %h expected none", out2_data);
                end else begin
                    check("out2 order", 16'(out2_data), 16'(q2.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                if (|(in_data[13:11] & 3'b001)) q2.push_back(in_data);
                else                            q1.push_back(in_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{data: 14'h0005, to_out2: 1'b0};
        vecs[1] = '{data: 14'h0805, to_out2: 1'b1};
        vecs[2] = '{data: 14'h3005, to_out2: 1'b0};
        vecs[3] = '{data: 14'h3FFF, to_out2: 1'b1};
        vecs[4] = '{data: 14'h37FF, to_out2: 1'b0};
        vecs[5] = '{data: 14'h2801, to_out2: 1'b1};

        tp[0] = 14'h0801;
        tp[1] = 14'h0002;
        tp[2] = 14'h0803;
        tp[3] = 14'h0004;

        // Reset with a valid packet presented
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 14'h0805;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        repeat (3) step();
        check("reset out1_valid", 16'(out1_valid), 16'h0);
        check("reset out2_valid", 16'(out2_valid), 16'h0);
        check("reset out1_data",  16'(out1_data),  16'h0);
        check("reset out2_data",  16'(out2_data),  16'h0);
        check("reset in_ready",   16'(in_ready),   16'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Routing table
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            #1;
            check("route in_ready", 16'(in_ready), 16'h1);
            step();
            in_valid = 1'b0;
            #1;
            if (vecs[i].to_out2) begin
                check("route out2_valid", 16'(out2_valid), 16'h1);
                check("route out2_data",  16'(out2_data),  16'(vecs[i].data));
                check("route out1_idle",  16'(out1_valid), 16'h0);
            end else begin
                check("route out1_valid", 16'(out1_valid), 16'h1);
                check("route out1_data",  16'(out1_data),  16'(vecs[i].data));
                check("route out2_idle",  16'(out2_valid), 16'h0);
            end
            step();
        end

        // Back-to-back throughput across alternating ports
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = tp[i];
            #1;
            check("tput in_ready", 16'(in_ready), 16'h1);
            step();
            if (i % 2 == 0) begin
                check("tput out2_valid", 16'(out2_valid), 16'h1);
                check("tput out2_data",  16'(out2_data),  16'(tp[i]));
                check("tput out1_idle",  16'(out1_valid), 16'h0);
            end else begin
                check("tput out1_valid", 16'(out1_valid), 16'h1);
                check("tput out1_data",  16'(out1_data),  16'(tp[i]));
                check("tput out2_idle",  16'(out2_valid), 16'h0);
            end
        end
        in_valid = 1'b0;
        step();

        // Backpressure on port 1
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 14'h0011;
        #1;
        check("bp first in_ready", 16'(in_ready), 16'h1);
        step();
        in_data = 14'h0022;
        #1;
        check("bp out1_valid", 16'(out1_valid), 16'h1);
        check("bp out1_data",  16'(out1_data),  16'h0011);
        check("bp blocked in_ready", 16'(in_ready), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp hold valid", 16'(out1_valid), 16'h1);
            check("bp hold data",  16'(out1_data),  16'h0011);
            check("bp hold in_ready", 16'(in_ready), 16'h0);
        end
        out1_ready = 1'b1;
        #1;
        check("bp release in_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("bp reload valid", 16'(out1_valid), 16'h1);
        check("bp reload data",  16'(out1_data),  16'h0022);
        step();
        check("bp drained", 16'(out1_valid), 16'h0);

        // Port independence and head-of-line blocking
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 14'h0044;
        step();
        in_data = 14'h0833;
        #1;
        check("ind in_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("ind out2_valid", 16'(out2_valid), 16'h1);
        check("ind out2_data",  16'(out2_data),  16'h0833);
        check("ind out1_valid", 16'(out1_valid), 16'h1);
        check("ind out1_data",  16'(out1_data),  16'h0044);
        step();
        check("ind out2_drained", 16'(out2_valid), 16'h0);
        check("ind out1_held",    16'(out1_data),  16'h0044);
        in_valid = 1'b1;
        in_data  = 14'h0055;
        #1;
        check("hol in_ready", 16'(in_ready), 16'h0);
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        step();
        check("hol out1 drained", 16'(out1_valid), 16'h0);

        // Mid-run asynchronous reset with both slots full
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        in_valid   = 1'b1;
        in_data    = 14'h0066;
        step();
        in_data = 14'h0877;
        #1;
        check("mr second in_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("mr full out1", 16'(out1_valid), 16'h1);
        check("mr full out2", 16'(out2_valid), 16'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr async out1_valid", 16'(out1_valid), 16'h0);
        check("mr async out2_valid", 16'(out2_valid), 16'h0);
        check("mr async out2_data",  16'(out2_data),  16'h0);
        check("mr async in_ready",   16'(in_ready),   16'h0);
        q1.delete();
        q2.delete();
        step();
        rst_n      = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        in_valid   = 1'b1;
        in_data    = 14'h0805;
        #1;
        check("mr resume in_ready", 16'(in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("mr resume out2_valid", 16'(out2_valid), 16'h1);
        check("mr resume out2_data",  16'(out2_data),  16'h0805);
        check("mr resume out1_valid", 16'(out1_valid), 16'h0);
        step();
        step();

        check("final q1 empty", 16'(q1.size()), 16'h0);
        check("final q2 empty", 16'(q2.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
